prio_arbiter_rr: RTL and testbench

//  Parametrised N-request arbiter with a registered grant. Priority is fixed
//  (MSB highest) or round-robin, selected at run time. The winner's binary index
//  and one-hot grant are held on a valid/ready handshake until the consumer

---
 rtl/prio_arbiter_rr.sv | 119 +++++++++++
 tb/tb_prio_arbiter_rr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr: N-way request arbiter, fixed (MSB first) or round-robin priority,
// with a registered grant held on a valid/ready handshake until accepted.

// One search slot: slot K of the descending search starting at 'start'.
module prio_arbiter_rr_lane #(
  parameter int N = 8,
  parameter int W = 3,
  parameter int K = 0
) (
  input  logic [W-1:0] start,
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         hit
);
  int s;
  int t;

  always_comb begin
    s   = int'(start);
    t   = (s >= K) ? s - K : s + N - K;
    idx = W'(t);
    hit = req[idx];
  end
endmodule

module prio_arbiter_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);
  localparam logic [0:0]   IDLE  = 1'b0;
  localparam logic [0:0]   GRANT = 1'b1;
  localparam logic [W-1:0] TOP   = W'(N - 1);

  logic [0:0]   state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0] gnt_onehot_q, gnt_onehot_d;

  logic         accept;
  logic         arb_go;
  logic [W-1:0] start;

  logic [N-1:0][W-1:0] cand_idx;
  logic [N-1:0]        cand_hit;
  logic                win_any;
  logic [W-1:0]        win_idx;

  // The pointer update on an accept feeds straight into the same-edge search,
  // so a round-robin winner becomes lowest priority immediately.
  always_comb begin
    accept = (state_q == GRANT) && gnt_ready;
    arb_go = (state_q == IDLE) || accept;
    ptr_d  = ptr_q;
    if (accept && mode)
      ptr_d = (gnt_idx_q == '0) ? TOP : gnt_idx_q - W'(1);
    start = mode ? ptr_d : TOP;
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    prio_arbiter_rr_lane #(.N(N), .W(W), .K(k)) u_lane (
      .start (start),
      .req   (req),
      .idx   (cand_idx[k]),
      .hit   (cand_hit[k])
    );
  end

  // Slot 0 is the highest-priority position; scan so the lowest slot wins.
  always_comb begin
    win_any = |cand_hit;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (cand_hit[k]) win_idx = cand_idx[k];
  end

  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    if (arb_go) begin
      if (win_any) begin
        state_d      = GRANT;
        gnt_idx_d    = win_idx;
        gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
      end else begin
        state_d      = IDLE;
        gnt_idx_d    = '0;
        gnt_onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= TOP;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
    end
  end

  assign gnt_valid  = (state_q == GRANT);
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;
endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr (N=8): vector table, directed corner sequences and
// randomized traffic checked against a queue-free index-arithmetic reference.
module tb_prio_arbiter_rr;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         mode = 1'b0;
  logic         gnt_ready = 1'b0;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;

  int n_cmp = 0;
  int n_err = 0;

  prio_arbiter_rr #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         mode;
    logic         ready;
    logic         exp_valid;
    int           exp_idx;
  } vec_t;

  vec_t vecs[15];

  // reference state: grant held, granted index, top-priority pointer
  bit m_valid;
  int m_idx;
  int m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input bit ev, input int ei);
    logic [N-1:0] oh;
    oh = ev ? N'(1 << ei) : '0;
    chk({name, ".valid"}, 32'(gnt_valid), 32'(ev));
    if (ev) chk({name, ".idx"}, 32'(gnt_idx), 32'(ei));
    chk({name, ".onehot"}, 32'(gnt_onehot), 32'(oh));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    m_valid = 0; m_idx = 0; m_ptr = N - 1;
  endtask

  // One arbitration edge, straight from the priority rules.
  function automatic void model_step(input logic [N-1:0] r, input bit md, input bit rdy);
    int st, j;
    if (m_valid && !rdy) return;
    if (m_valid && md) m_ptr = (m_idx + N - 1) % N;
    st = md ? m_ptr : N - 1;
    m_valid = 0;
    m_idx = 0;
    for (int k = 0; k < N; k++) begin
      j = (st - k + N) % N;
      if (r[j]) begin
        m_valid = 1;
        m_idx = j;
        break;
      end
    end
  endfunction

  initial begin
    vecs[0]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 7};
    vecs[1]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 6};
    vecs[2]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 5};
    vecs[3]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 4};
    vecs[4]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3};
    vecs[5]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 2};
    vecs[6]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 1};
    vecs[7]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 0};
    vecs[8]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 7};
    vecs[9]  = '{8'h2C, 1'b0, 1'b1, 1'b1, 5};
    vecs[10] = '{8'h2C, 1'b0, 1'b1, 1'b1, 5};
    vecs[11] = '{8'h2C, 1'b0, 1'b1, 1'b1, 5};
    vecs[12] = '{8'h2C, 1'b0, 1'b1, 1'b1, 5};
    vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 0};
    vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 0};

    // reset clears outputs asynchronously, before any clock edge
    req = 8'hFF; mode = 1'b1; gnt_ready = 1'b0;
    #2;
    chk_out("reset_initial", 1'b0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk_out("first_grant", 1'b1, 7);
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset_midgrant", 1'b0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("after_reset_ptr_top", 1'b1, 7);

    // table: round-robin sweep with wrap, then fixed priority, then drain
    do_reset();
    for (int i = 0; i < 15; i++) begin
      req = vecs[i].req; mode = vecs[i].mode; gnt_ready = vecs[i].ready;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx);
    end

    // sticky grant while stalled, req changes underneath
    do_reset();
    mode = 1'b0; gnt_ready = 1'b0; req = 8'h08;
    tick();
    chk_out("sticky_grant", 1'b1, 3);
    req = 8'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("sticky_hold%0d", i), 1'b1, 3);
    end
    gnt_ready = 1'b1;
    tick();
    chk_out("sticky_accept", 1'b1, 6);

    // round-robin wrap from idx 0, then drain to idle
    do_reset();
    mode = 1'b1; gnt_ready = 1'b0; req = 8'h01;
    tick();
    chk_out("wrap_idx0", 1'b1, 0);
    req = 8'h81; gnt_ready = 1'b1;
    tick();
    chk_out("wrap_to7", 1'b1, 7);
    req = 8'h00;
    tick();
    chk_out("wrap_drain", 1'b0, 0);

    // mode toggles during a held grant are ignored until the accept edge
    do_reset();
    mode = 1'b1; gnt_ready = 1'b0; req = 8'hFF;
    tick();
    chk_out("mode_hold_start", 1'b1, 7);
    for (int i = 0; i < 3; i++) begin
      mode = ~mode;
      tick();
      chk_out($sformatf("mode_toggle%0d", i), 1'b1, 7);
    end
    mode = 1'b0; gnt_ready = 1'b1;
    tick();
    chk_out("mode_fixed_at_accept", 1'b1, 7);
    mode = 1'b1;
    tick();
    chk_out("mode_rr_at_accept", 1'b1, 6);

    // randomized traffic against the reference
    do_reset();
    req = '0; gnt_ready = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = N'(1 << $urandom_range(0, N - 1));
        default: req = N'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      gnt_ready = ($urandom_range(0, 2) != 0);
      model_step(req, mode, gnt_ready);
      tick();
      chk_out($sformatf("rand%0d", c), m_valid, m_idx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
